// File: rtl/turf_generic_pkg.sv
// Shared types and constants for the TURF generic register scheduler.
// Imported by the selector and the scheduler top.
package turf_generic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } sched_state_t;

    localparam int TURF_ADDR_W = 28;
    localparam int TURF_DATA_W = 32;

    localparam logic [TURF_DATA_W-1:0] ERR_DATA = 32'hBAADF00D;

endpackage

// File: rtl/turf_rr_select.sv
// Circular priority encoder: first set request searching upward
// from (last_i+1) mod NPORTS.
module turf_rr_select
    import turf_generic_pkg::*;
#(
    parameter  int NPORTS = 4,
    localparam int IW     = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] req_i,
    input  logic [IW-1:0]     last_i,
    output logic [NPORTS-1:0] gnt_o,
    output logic [IW-1:0]     idx_o,
    output logic              valid_o
);

    int          p;
    logic [IW-1:0] pi;

    // Walk the ports in rotated order and keep the first hit.
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        p       = 0;
        pi      = '0;
        for (int i = 1; i <= NPORTS; i++) begin
            p  = (int'(last_i) + i) % NPORTS;
            pi = IW'(p);
            if (!valid_o && req_i[pi]) begin
                valid_o   = 1'b1;
                idx_o     = pi;
                gnt_o[pi] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/turf_generic_sched.sv
// N-port round-robin scheduler onto one TURF generic master port,
// with a per-transaction watchdog that aborts stalled accesses.
module turf_generic_sched
    import turf_generic_pkg::*;
#(
    parameter  int NPORTS  = 4,
    parameter  int ADDR_W  = TURF_ADDR_W,
    parameter  int DATA_W  = TURF_DATA_W,
    parameter  int TIMEOUT = 255,
    localparam int GW      = $clog2(NPORTS),
    localparam int WW      = $clog2(TIMEOUT + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        s_en_i,
    input  logic [NPORTS-1:0]        s_wr_i,
    input  logic [NPORTS*ADDR_W-1:0] s_adr_i,
    input  logic [NPORTS*DATA_W-1:0] s_dat_i,
    output logic [NPORTS-1:0]        s_ack_o,
    output logic [NPORTS-1:0]        s_err_o,
    output logic [DATA_W-1:0]        s_dat_o,
    output logic                     m_en_o,
    output logic                     m_wr_o,
    output logic [ADDR_W-1:0]        m_adr_o,
    output logic [DATA_W-1:0]        m_dat_o,
    input  logic                     m_ack_i,
    input  logic [DATA_W-1:0]        m_dat_i,
    output logic [GW-1:0]            grant_o,
    output logic                     busy_o,
    output logic [7:0]               tmo_count_o
);

    sched_state_t        state_q, state_d;
    logic [GW-1:0]       last_q, last_d;
    logic [GW-1:0]       grant_q, grant_d;
    logic                m_en_q, m_en_d;
    logic                m_wr_q, m_wr_d;
    logic [ADDR_W-1:0]   m_adr_q, m_adr_d;
    logic [DATA_W-1:0]   m_dat_q, m_dat_d;
    logic [NPORTS-1:0]   s_ack_q, s_ack_d;
    logic [NPORTS-1:0]   s_err_q, s_err_d;
    logic [DATA_W-1:0]   s_dat_q, s_dat_d;
    logic                busy_q, busy_d;
    logic [7:0]          tmo_q, tmo_d;
    logic [WW-1:0]       wd_q, wd_d;

    logic [NPORTS-1:0]   sel_oh;
    logic [GW-1:0]       sel_idx;
    logic                sel_valid;
    logic                sel_wr;
    logic [ADDR_W-1:0]   sel_adr;
    logic [DATA_W-1:0]   sel_dat;

    turf_rr_select #(
        .NPORTS (NPORTS)
    ) u_sel (
        .req_i   (s_en_i),
        .last_i  (last_q),
        .gnt_o   (sel_oh),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // AND-OR mux of the winning port's request fields.
    always_comb begin
        sel_wr  = 1'b0;
        sel_adr = '0;
        sel_dat = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (sel_oh[p]) begin
                sel_wr  = sel_wr  | s_wr_i[p];
                sel_adr = sel_adr | s_adr_i[p*ADDR_W +: ADDR_W];
                sel_dat = sel_dat | s_dat_i[p*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state and registered-output logic; ack beats timeout in BUSY.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        m_en_d  = m_en_q;
        m_wr_d  = m_wr_q;
        m_adr_d = m_adr_q;
        m_dat_d = m_dat_q;
        s_ack_d = '0;
        s_err_d = '0;
        s_dat_d = s_dat_q;
        busy_d  = busy_q;
        tmo_d   = tmo_q;
        wd_d    = wd_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d = BUSY;
                    m_en_d  = 1'b1;
                    m_wr_d  = sel_wr;
                    m_adr_d = sel_adr;
                    m_dat_d = sel_dat;
                    grant_d = sel_idx;
                    last_d  = sel_idx;
                    busy_d  = 1'b1;
                    wd_d    = WW'(1);
                end
            end
            BUSY: begin
                if (m_ack_i) begin
                    state_d          = ACK;
                    m_en_d           = 1'b0;
                    s_dat_d          = m_dat_i;
                    s_ack_d[grant_q] = 1'b1;
                end else if (wd_q == WW'(TIMEOUT)) begin
                    state_d          = ACK;
                    m_en_d           = 1'b0;
                    s_dat_d          = DATA_W'(ERR_DATA);
                    s_ack_d[grant_q] = 1'b1;
                    s_err_d[grant_q] = 1'b1;
                    if (tmo_q != 8'hFF) begin
                        tmo_d = tmo_q + 8'd1;
                    end
                end else begin
                    wd_d = wd_q + WW'(1);
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; last_q resets so port 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= GW'(NPORTS - 1);
            grant_q <= '0;
            m_en_q  <= 1'b0;
            m_wr_q  <= 1'b0;
            m_adr_q <= '0;
            m_dat_q <= '0;
            s_ack_q <= '0;
            s_err_q <= '0;
            s_dat_q <= '0;
            busy_q  <= 1'b0;
            tmo_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            m_en_q  <= m_en_d;
            m_wr_q  <= m_wr_d;
            m_adr_q <= m_adr_d;
            m_dat_q <= m_dat_d;
            s_ack_q <= s_ack_d;
            s_err_q <= s_err_d;
            s_dat_q <= s_dat_d;
            busy_q  <= busy_d;
            tmo_q   <= tmo_d;
            wd_q    <= wd_d;
        end
    end

    assign s_ack_o     = s_ack_q;
    assign s_err_o     = s_err_q;
    assign s_dat_o     = s_dat_q;
    assign m_en_o      = m_en_q;
    assign m_wr_o      = m_wr_q;
    assign m_adr_o     = m_adr_q;
    assign m_dat_o     = m_dat_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;
    assign tmo_count_o = tmo_q;

endmodule

// File: tb/tb_turf_generic_sched.sv
// Self-checking bench for turf_generic_sched: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_turf_generic_sched;

    localparam int NP  = 4;
    localparam int AW  = 28;
    localparam int DW  = 32;
    localparam int TMO = 8;
    localparam int GW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NP-1:0]     s_en_i;
    logic [NP-1:0]     s_wr_i;
    logic [NP*AW-1:0]  s_adr_i;
    logic [NP*DW-1:0]  s_dat_i;
    logic [NP-1:0]     s_ack_o;
    logic [NP-1:0]     s_err_o;
    logic [DW-1:0]     s_dat_o;
    logic              m_en_o;
    logic              m_wr_o;
    logic [AW-1:0]     m_adr_o;
    logic [DW-1:0]     m_dat_o;
    logic              m_ack_i;
    logic [DW-1:0]     m_dat_i;
    logic [GW-1:0]     grant_o;
    logic              busy_o;
    logic [7:0]        tmo_count_o;

    int n_cmp = 0;
    int n_bad = 0;

    int            slv_lat = 0;
    logic [DW-1:0] slv_dat = '0;
    int            slv_cnt = 0;

    always #5 clk = ~clk;

    turf_generic_sched #(
        .NPORTS  (NP),
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .s_en_i      (s_en_i),
        .s_wr_i      (s_wr_i),
        .s_adr_i     (s_adr_i),
        .s_dat_i     (s_dat_i),
        .s_ack_o     (s_ack_o),
        .s_err_o     (s_err_o),
        .s_dat_o     (s_dat_o),
        .m_en_o      (m_en_o),
        .m_wr_o      (m_wr_o),
        .m_adr_o     (m_adr_o),
        .m_dat_o     (m_dat_o),
        .m_ack_i     (m_ack_i),
        .m_dat_i     (m_dat_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .tmo_count_o (tmo_count_o)
    );

    // Slave: acks in the (slv_lat+1)-th cycle that m_en_o is high.
    initial begin
        m_ack_i = 1'b0;
        m_dat_i = '0;
        forever begin
            @(negedge clk);
            if (rst || !m_en_o) begin
                slv_cnt = 0;
                m_ack_i = 1'b0;
            end else begin
                slv_cnt++;
                m_ack_i = (slv_cnt == slv_lat + 1);
                m_dat_i = m_ack_i ? slv_dat : DW'($urandom);
            end
        end
    end

    task automatic do_reset();
        rst     = 1'b1;
        s_en_i  = '0;
        s_wr_i  = '0;
        s_adr_i = '0;
        s_dat_i = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_port(input int p, input logic wr,
                            input logic [AW-1:0] a, input logic [DW-1:0] d);
        s_en_i[p]          = 1'b1;
        s_wr_i[p]          = wr;
        s_adr_i[p*AW +: AW] = a;
        s_dat_i[p*DW +: DW] = d;
    endtask

    task automatic wait_en(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_en_o) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_ack(output bit ok, output int en_cyc,
                            output logic [NP-1:0] ack, output logic [NP-1:0] err,
                            output logic [DW-1:0] d, output logic [7:0] t);
        ok = 1'b0; en_cyc = 0; ack = '0; err = '0; d = '0; t = '0;
        for (int i = 0; i < 3*TMO + 10; i++) begin
            if (m_en_o) en_cyc++;
            if (|s_ack_o) begin
                ok = 1'b1; ack = s_ack_o; err = s_err_o;
                d = s_dat_o; t = tmo_count_o;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [255:0] outs;
        rst = 1'b1;
        s_en_i = '0; s_wr_i = '0; s_adr_i = '0; s_dat_i = '0;
        @(negedge clk);
        outs = {s_ack_o, s_err_o, s_dat_o, m_en_o, m_wr_o, m_adr_o,
                m_dat_o, grant_o, busy_o, tmo_count_o};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", outs);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({m_en_o, busy_o, s_ack_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_idle: got en=%b busy=%b ack=%b want 0",
                     m_en_o, busy_o, s_ack_o);
        end
    endtask

    task automatic test_single_read();
        bit ok; int ec; logic [NP-1:0] a, e; logic [DW-1:0] d; logic [7:0] t;
        do_reset();
        slv_lat = 3;
        slv_dat = 32'h1234_5678;
        set_port(2, 1'b0, 28'hABC_DEF0, 32'h5555_AAAA);
        wait_en(ok);
        n_cmp++;
        if (!ok || m_adr_o !== 28'hABC_DEF0 || grant_o !== 2'd2 || m_wr_o !== 1'b0) begin
            n_bad++;
            $display("FAIL rd_issue: got ok=%0d adr=%h g=%0d wr=%b want adr=abcdef0 g=2 wr=0",
                     ok, m_adr_o, grant_o, m_wr_o);
        end
        wait_ack(ok, ec, a, e, d, t);
        n_cmp++;
        if (!ok || a !== 4'b0100 || e !== 4'b0000 || d !== 32'h1234_5678 || ec != 4) begin
            n_bad++;
            $display("FAIL rd_ack: got ok=%0d ack=%b err=%b dat=%h en=%0d want 0100 0000 12345678 4",
                     ok, a, e, d, ec);
        end
        s_en_i[2] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (s_ack_o !== '0) begin
            n_bad++;
            $display("FAIL rd_ack_pulse: got %b want 0000", s_ack_o);
        end
    endtask

    task automatic test_round_robin();
        int gcyc[5];
        int gidx[5];
        int n = 0;
        logic prev = 1'b0;
        do_reset();
        slv_lat = 0;
        for (int p = 0; p < NP; p++) set_port(p, 1'b1, AW'(p), DW'(p));
        for (int c = 0; c < 40 && n < 5; c++) begin
            @(negedge clk);
            if (m_en_o && !prev) begin
                gcyc[n] = c;
                gidx[n] = int'(grant_o);
                n++;
            end
            prev = m_en_o;
        end
        s_en_i = '0;
        n_cmp++;
        if (n != 5) begin
            n_bad++;
            $display("FAIL rr_count: got %0d grants want 5", n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (gidx[i] != i % NP) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: got %0d want %0d", i, gidx[i], i % NP);
                end
                if (i > 0) begin
                    n_cmp++;
                    if (gcyc[i] - gcyc[i-1] != 3) begin
                        n_bad++;
                        $display("FAIL rr_period[%0d]: got %0d want 3", i, gcyc[i] - gcyc[i-1]);
                    end
                end
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int ec; logic [NP-1:0] a, e; logic [DW-1:0] d; logic [7:0] t;
        do_reset();
        slv_lat = 1000;
        set_port(1, 1'b1, 28'h000_0040, 32'hCAFE_0001);
        wait_en(ok);
        wait_ack(ok, ec, a, e, d, t);
        n_cmp++;
        if (!ok || ec != TMO || a !== 4'b0010 || e !== 4'b0010 ||
            d !== 32'hBAAD_F00D || t !== 8'd1) begin
            n_bad++;
            $display("FAIL timeout: got ok=%0d en=%0d ack=%b err=%b dat=%h tmo=%0d want 8 0010 0010 baadf00d 1",
                     ok, ec, a, e, d, t);
        end
        s_en_i[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_ack_at_timeout();
        bit ok; int ec; logic [NP-1:0] a, e; logic [DW-1:0] d; logic [7:0] t;
        slv_lat = TMO - 1;
        slv_dat = 32'h0BAD_CAFE;
        set_port(3, 1'b0, 28'h000_0100, 32'h0);
        wait_en(ok);
        wait_ack(ok, ec, a, e, d, t);
        n_cmp++;
        if (!ok || ec != TMO || a !== 4'b1000 || e !== 4'b0000 ||
            d !== 32'h0BAD_CAFE || t !== 8'd1) begin
            n_bad++;
            $display("FAIL ack_at_tmo: got ok=%0d en=%0d ack=%b err=%b dat=%h tmo=%0d want 8 1000 0000 0badcafe 1",
                     ok, ec, a, e, d, t);
        end
        s_en_i[3] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit ok; bit seen; logic [255:0] outs;
        int ec; logic [NP-1:0] a, e; logic [DW-1:0] d; logic [7:0] t;
        do_reset();
        slv_lat = 1000;
        set_port(1, 1'b1, 28'hFFF_FFFF, 32'hFFFF_FFFF);
        wait_en(ok);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        outs = {s_ack_o, s_err_o, s_dat_o, m_en_o, m_wr_o, m_adr_o,
                m_dat_o, grant_o, busy_o, tmo_count_o};
        n_cmp++;
        if (outs !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got %h want 0", outs);
        end
        s_en_i = '0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (|s_ack_o) seen = 1'b1;
        end
        rst = 1'b0;
        slv_lat = 0;
        set_port(0, 1'b0, 28'h000_0010, 32'h0);
        set_port(3, 1'b0, 28'h000_0030, 32'h0);
        wait_en(ok);
        n_cmp++;
        if (seen || !ok || grant_o !== 2'd0) begin
            n_bad++;
            $display("FAIL rst_mid_prio: got ack_seen=%0d ok=%0d grant=%0d want 0 1 0",
                     seen, ok, grant_o);
        end
        wait_ack(ok, ec, a, e, d, t);
        s_en_i = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturation();
        bit ok; int ec; logic [NP-1:0] a, e; logic [DW-1:0] d; logic [7:0] t;
        bit lost = 1'b0;
        do_reset();
        slv_lat = 1000;
        for (int i = 0; i < 300; i++) begin
            set_port(i % NP, 1'b0, AW'(i), DW'(0));
            wait_en(ok);
            if (!ok) lost = 1'b1;
            wait_ack(ok, ec, a, e, d, t);
            if (!ok) lost = 1'b1;
            s_en_i = '0;
            if (i == 99) begin
                n_cmp++;
                if (t !== 8'd100) begin
                    n_bad++;
                    $display("FAIL tmo_count_100: got %0d want 100", t);
                end
            end
        end
        n_cmp++;
        if (lost || tmo_count_o !== 8'd255) begin
            n_bad++;
            $display("FAIL tmo_saturate: got lost=%0d tmo=%0d want 0 255", lost, tmo_count_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        bit            pend[NP];
        logic          rwr[NP];
        logic [AW-1:0] radr[NP];
        logic [DW-1:0] rdat[NP];
        int            mlast = NP - 1;
        int            mtmo  = 0;
        int            p, lat, ec;
        bit            ok, exp_err;
        logic [NP-1:0] a, e, exp_ack;
        logic [DW-1:0] d, exp_dat;
        logic [7:0]    t;
        do_reset();
        for (int i = 0; i < NP; i++) pend[i] = 1'b0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NP; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    rwr[i]  = 1'($urandom);
                    radr[i] = AW'($urandom);
                    rdat[i] = DW'($urandom);
                end
            end
            if (!(pend[0] || pend[1] || pend[2] || pend[3])) begin
                p = $urandom_range(0, NP - 1);
                pend[p] = 1'b1; rwr[p] = 1'b1;
                radr[p] = AW'($urandom); rdat[p] = DW'($urandom);
            end
            for (int i = 0; i < NP; i++) begin
                s_en_i[i] = pend[i];
                s_wr_i[i] = rwr[i];
                s_adr_i[i*AW +: AW] = radr[i];
                s_dat_i[i*DW +: DW] = rdat[i];
            end
            p = -1;
            for (int k = 1; k <= NP && p < 0; k++) begin
                if (pend[(mlast + k) % NP]) p = (mlast + k) % NP;
            end
            mlast = p;
            lat = $urandom_range(0, TMO + 1);
            slv_lat = lat;
            slv_dat = DW'($urandom);
            exp_err = (lat + 1 > TMO);
            exp_dat = exp_err ? 32'hBAAD_F00D : slv_dat;
            if (exp_err && mtmo < 255) mtmo++;
            exp_ack = NP'(1) << p;
            wait_en(ok);
            n_cmp++;
            if (!ok || int'(grant_o) != p || m_adr_o !== radr[p] ||
                m_wr_o !== rwr[p] || m_dat_o !== rdat[p] || busy_o !== 1'b1) begin
                n_bad++;
                $display("FAIL rnd_issue[%0d]: got ok=%0d g=%0d adr=%h wr=%b dat=%h busy=%b want g=%0d adr=%h wr=%b dat=%h busy=1",
                         it, ok, grant_o, m_adr_o, m_wr_o, m_dat_o, busy_o,
                         p, radr[p], rwr[p], rdat[p]);
            end
            wait_ack(ok, ec, a, e, d, t);
            n_cmp++;
            if (!ok || a !== exp_ack || e !== (exp_err ? exp_ack : '0) ||
                d !== exp_dat || int'(t) != mtmo || ec != (exp_err ? TMO : lat + 1)) begin
                n_bad++;
                $display("FAIL rnd_ack[%0d]: got ok=%0d ack=%b err=%b dat=%h tmo=%0d en=%0d want ack=%b err=%0d dat=%h tmo=%0d lat=%0d",
                         it, ok, a, e, d, t, ec, exp_ack, exp_err, exp_dat, mtmo, lat);
            end
            pend[p] = 1'b0;
            s_en_i[p] = 1'b0;
        end
        s_en_i = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        s_en_i  = '0;
        s_wr_i  = '0;
        s_adr_i = '0;
        s_dat_i = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_timeout();
        test_ack_at_timeout();
        test_reset_mid();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
